// File: rtl/mem_access.sv
// MEM pipeline stage: drives the data-memory handshake, stalls the pipe while
// an access is outstanding, extracts the loaded byte/half/word and holds the
// MEM/WB pipeline register. All state advances on the falling clock edge.
module mem_access (
  input  logic        clk,
  input  logic        reset,
  input  logic        cu_stall,
  input  logic        cu_flush,
  input  logic        exmem_mem_r,
  input  logic        exmem_mem_w,
  input  logic        exmem_reg_w,
  input  logic [4:0]  exmem_rd_addr,
  input  logic [31:0] exmem_alu_res,
  input  logic [31:0] exmem_aligned_rt_data,
  input  logic [3:0]  mem_byte_w_en_in,
  input  logic [2:0]  exmem_load_sel,
  input  logic [31:0] exmem_pc,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        mem_stall,
  output logic        memwb_reg_w,
  output logic [4:0]  memwb_rd_addr,
  output logic [31:0] memwb_data,
  output logic [31:0] memwb_pc
);

  // IDLE: no access outstanding. BUSY: request issued, waiting for ack.
  // DONE: data captured but the pipe is frozen by someone else; no re-issue.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_hold;
  logic        w_hold_ld;

  logic        w_access;
  logic        w_advance;
  logic [1:0]  w_lane;
  logic [31:0] w_raw;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load;
  logic [31:0] w_result;

  logic        r_memwb_reg_w;
  logic [4:0]  r_memwb_rd_addr;
  logic [31:0] r_memwb_data;
  logic [31:0] r_memwb_pc;

  assign w_access  = exmem_mem_r | exmem_mem_w;
  assign w_advance = !cu_stall && !mem_stall;
  assign w_lane    = exmem_alu_res[1:0];

  // Memory interface: request only from IDLE with a pending access, or while BUSY.
  assign dmem_req   = ((r_state == S_IDLE) && w_access) || (r_state == S_BUSY);
  assign dmem_we    = dmem_req && exmem_mem_w;
  assign dmem_addr  = {exmem_alu_res[31:2], 2'b00};
  assign dmem_wdata = exmem_aligned_rt_data;
  assign dmem_be    = dmem_we ? mem_byte_w_en_in : 4'b0000;

  // Stall is combinational from dmem_ack so a same-cycle ack costs nothing.
  assign mem_stall = ((r_state == S_IDLE) && w_access && !dmem_ack) ||
                     ((r_state == S_BUSY) && !dmem_ack);

  // Next-state logic for the memory handshake.
  always_comb begin
    // NOTE: every signal assigned here gets a default first so no path can
    // leave it unassigned and infer a latch.
    w_state_nxt = r_state;
    w_hold_ld   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_access) begin
          if (!dmem_ack) begin
            w_state_nxt = S_BUSY;
          end else if (cu_stall) begin
            w_state_nxt = S_DONE;
            w_hold_ld   = 1'b1;
          end
        end
      end
      S_BUSY: begin
        if (dmem_ack) begin
          if (cu_stall) begin
            w_state_nxt = S_DONE;
            w_hold_ld   = 1'b1;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      S_DONE: begin
        if (!cu_stall) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State and hold register; reset wins even in the middle of an access.
  always_ff @(negedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (reset) begin
      r_state <= S_IDLE;
      // NOTE: the hold word is a single register, not a memory array, so it is
      // cleared on reset like any other state.
      r_hold  <= 32'h0;
    end else begin
      r_state <= w_state_nxt;
      if (w_hold_ld) r_hold <= dmem_rdata;
    end
  end

  // Load extraction: pick the little-endian lane, then sign/zero-extend.
  always_comb begin
    w_raw  = (r_state == S_DONE) ? r_hold : dmem_rdata;
    w_byte = 8'h00;
    case (w_lane)
      2'd0: w_byte = w_raw[7:0];
      2'd1: w_byte = w_raw[15:8];
      2'd2: w_byte = w_raw[23:16];
      2'd3: w_byte = w_raw[31:24];
      default: w_byte = 8'h00;
    endcase
    w_half = w_lane[1] ? w_raw[31:16] : w_raw[15:0];
    w_load = w_raw;
    case (exmem_load_sel)
      3'd1:    w_load = {{24{w_byte[7]}}, w_byte};
      3'd2:    w_load = {24'h0, w_byte};
      3'd3:    w_load = {{16{w_half[15]}}, w_half};
      3'd4:    w_load = {16'h0, w_half};
      default: w_load = w_raw;
    endcase
    w_result = exmem_mem_r ? w_load : exmem_alu_res;
  end

  // MEM/WB register: load on advance, clear on flushed advance, else hold.
  always_ff @(negedge clk) begin
    if (reset) begin
      r_memwb_reg_w   <= 1'b0;
      r_memwb_rd_addr <= 5'd0;
      r_memwb_data    <= 32'h0;
      r_memwb_pc      <= 32'h0;
    end else if (w_advance) begin
      if (cu_flush) begin
        r_memwb_reg_w   <= 1'b0;
        r_memwb_rd_addr <= 5'd0;
        r_memwb_data    <= 32'h0;
        r_memwb_pc      <= 32'h0;
      end else begin
        r_memwb_reg_w   <= exmem_reg_w;
        r_memwb_rd_addr <= exmem_rd_addr;
        r_memwb_data    <= w_result;
        r_memwb_pc      <= exmem_pc;
      end
    end
  end

  assign memwb_reg_w   = r_memwb_reg_w;
  assign memwb_rd_addr = r_memwb_rd_addr;
  assign memwb_data    = r_memwb_data;
  assign memwb_pc      = r_memwb_pc;

endmodule

// File: doc/mem_access.md
MEM_ACCESS -- requirements
Module: mem_access

Interface
REQ-001 The block SHALL have these ports (name  direction  width  meaning):
- clk  in  1  single clock; all state updates on falling edge, same as pipeline registers
- reset  in  1  synchronous, active-high
- cu_stall  in  1  stall demand from all sources other than this block
- cu_flush  in  1  flush request for the MEM/WB stage
- exmem_mem_r, exmem_mem_w  in  1 each  load / store in MEM stage
- exmem_reg_w  in  1  register write enable
- exmem_rd_addr  in  5  destination register
- exmem_alu_res  in  32  effective address, or result for non-memory ops
- exmem_aligned_rt_data  in  32  store data, already lane-aligned
- mem_byte_w_en_in  in  4  store byte enables
- exmem_load_sel  in  3  load type
- exmem_pc  in  32  instruction PC
- dmem_req  out  1  memory request
- dmem_we  out  1  write (1) / read (0)
- dmem_addr  out  32  {exmem_alu_res[31:2],2'b00}
- dmem_wdata  out  32  exmem_aligned_rt_data
- dmem_be  out  4  mem_byte_w_en_in when writing, 4'b0000 when reading
- dmem_ack  in  1  access complete; dmem_rdata valid in the same cycle
- dmem_rdata  in  32  read word
- mem_stall  out  1  MEM stage waiting on memory
- memwb_reg_w  out  1, memwb_rd_addr  out  5, memwb_data  out  32, memwb_pc  out  32  MEM/WB register

Function
REQ-002 access SHALL be exmem_mem_r | exmem_mem_w; advance SHALL be !cu_stall & !mem_stall.
REQ-003 FSM states SHALL be IDLE, BUSY and DONE, with a 32-bit hold register.
REQ-004 dmem_req SHALL be 1 in (IDLE & access) or in BUSY, and 0 in DONE.
REQ-005 mem_stall SHALL be (IDLE & access & !dmem_ack) | (BUSY & !dmem_ack); this path is combinational from dmem_ack.
REQ-006 IDLE SHALL go to BUSY on access & !dmem_ack.
REQ-007 IDLE or BUSY with dmem_ack=1 (and access or BUSY) SHALL go to DONE with hold<=dmem_rdata if cu_stall=1, otherwise to IDLE.
REQ-008 DONE SHALL go to IDLE when cu_stall=0; it SHALL never re-issue a request.
REQ-009 The raw word SHALL be hold in DONE and dmem_rdata otherwise.
REQ-010 Lane b=exmem_alu_res[1:0], little-endian; halfword uses lane b[1].
REQ-011 Load decode: 0 LW = raw word; 1 LB = sign-extended byte b; 2 LBU = zero-extended byte b; 3 LH = sign-extended half; 4 LHU = zero-extended half; 5-7 treated as LW.
REQ-012 The result SHALL be the loaded value when exmem_mem_r=1, otherwise exmem_alu_res.
REQ-013 The MEM/WB register on advance SHALL load: memwb_reg_w<=exmem_reg_w, memwb_rd_addr, memwb_data<=result, memwb_pc<=exmem_pc.
REQ-014 Flush on advance & cu_flush SHALL clear all MEM/WB outputs to 0.
REQ-015 Without advance the MEM/WB outputs SHALL hold.
REQ-016 cu_flush SHALL NOT abort an in-flight access; BUSY always completes, so a store is never torn.
REQ-017 Latency: a 1-cycle ack gives zero stall cycles; an ack after N extra cycles gives N stall cycles.
REQ-018 Misaligned addresses SHALL raise no exception; the lane is selected per REQ-010.

Reset
REQ-019 On reset=1 at a falling edge: state IDLE, hold 0, memwb_reg_w 0, memwb_rd_addr 0, memwb_data 0, memwb_pc 0.
REQ-020 Reset SHALL take priority over all other inputs, including mid-BUSY; any later dmem_ack for the aborted access is ignored unless access is pending.

Verification
REQ-021 Non-memory op, alu_res=0x1234, reg_w=1, rd=5 -> no dmem_req; next edge memwb_data=0x1234, rd=5.
REQ-022 LB, addr 0x103, dmem_rdata=0x80FF_FFFF, immediate ack -> memwb_data=0xFFFF_FF80; mem_stall never 1.
REQ-023 LHU, addr 0x102, ack after 3 cycles, rdata=0xBEEF_0000 -> mem_stall=1 for 3 cycles, then memwb_data=0x0000_BEEF.
REQ-024 SW, be=4'b1111, ack while cu_stall=1 for 2 more cycles -> state DONE, dmem_req 0, exactly one write; MEM/WB updates when cu_stall falls.
REQ-025 LW in BUSY, reset pulse -> MEM/WB all 0, state IDLE, dmem_req follows access on the next cycle.
REQ-026 cu_flush=1 with LW, ack after 2 cycles -> access completes, then MEM/WB cleared (reg_w=0).
